// File: rtl/aibnd_red_shift_ctrl_pkg.sv
// Shared types and helpers for the AIB redundancy shift controller.
// Holds default geometry, the FSM state enum and the thermometer decode used by wrapper models.
package aibnd_red_pkg;

  localparam int DEF_NUM_IO     = 24;
  localparam int DEF_IDX_W      = 5;
  localparam int DEF_SETTLE_CYC = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_CHECK,
    ST_SETTLE,
    ST_DONE,
    ST_ERR
  } red_state_e;

  function automatic int frame_w(input int idx_w);
    return idx_w + 2;
  endfunction

  // Wrapper i takes its neighbour path when it sits at or above the failing IO.
  function automatic logic [DEF_NUM_IO-1:0] therm_from_idx(input logic [DEF_IDX_W-1:0] idx,
                                                           input logic en);
    logic [DEF_NUM_IO-1:0] v;
    v = '0;
    for (int i = 0; i < DEF_NUM_IO; i++) begin
      v[i] = en && (i >= 32'(idx));
    end
    return v;
  endfunction

endpackage

// File: rtl/aibnd_red_shift_ctrl_if.sv
// Serial repair-word port from the fuse/config chain into the redundancy controller.
// cfg_data is taken on a cycle where cfg_valid and cfg_ready are both high.
interface aibnd_red_shift_ctrl_if;
  logic cfg_start;
  logic cfg_valid;
  logic cfg_data;
  logic cfg_ready;

  modport master (output cfg_start, output cfg_valid, output cfg_data, input cfg_ready);
  modport slave  (input cfg_start, input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/aibnd_red_shift_ctrl_deser.sv
// Repair-word deserializer: MSB-first shift register with bit counter; frame_vld flags the final accepted bit.
// Latency: frame is complete in frame_q the cycle after frame_vld; backpressure: bits only taken while bit_rdy.
module aibnd_red_deser
  import aibnd_red_pkg::*;
#(
  parameter int FRAME_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               bit_rdy,
  input  logic               bit_vld,
  input  logic               bit_dat,
  output logic               frame_vld,
  output logic [FRAME_W-1:0] frame
);

  localparam int CNT_W = $clog2(FRAME_W + 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               accept;
  logic               last_bit;

  // A restart in the same cycle as a bit wins: that bit belongs to the discarded frame.
  assign accept   = bit_vld && bit_rdy && !clr;
  assign last_bit = (cnt_q == CNT_W'(FRAME_W - 1));

  always_comb begin
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    frame_vld = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (accept) begin
      frame_d   = {frame_q[FRAME_W-2:0], bit_dat};
      cnt_d     = last_bit ? '0 : cnt_q + 1'b1;
      frame_vld = last_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      frame_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  assign frame = frame_q;

endmodule

// File: rtl/aibnd_red_shift_ctrl.sv
// Redundancy shift-enable controller: receives, validates and applies the repair word, then reports settled.
// Latency: last bit -> red_done in 1 + SETTLE_CYC + 1 cycles; backpressure: cfg_ready only while receiving.
module aibnd_red_shift_ctrl
  import aibnd_red_pkg::*;
#(
  parameter int NUM_IO     = DEF_NUM_IO,
  parameter int IDX_W      = DEF_IDX_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic                    clk,
  input  logic                    rst,
  aibnd_red_shift_ctrl_if.slave   cfg,
  output logic [NUM_IO-1:0]       shift_en,
  output logic                    red_busy,
  output logic                    red_done,
  output logic                    red_err
);

  localparam int FRAME_W = frame_w(IDX_W);
  localparam int SET_W   = $clog2(SETTLE_CYC + 1);

  red_state_e         state_q, state_d;
  logic [NUM_IO-1:0]  shift_en_q, shift_en_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               ready_q, ready_d;

  logic               start_acc;
  logic               frame_vld;
  logic [FRAME_W-1:0] frame;
  logic               repair_en;
  logic [IDX_W-1:0]   idx;
  logic               bad_word;
  logic [NUM_IO-1:0]  therm;

  // Once the word is committed (CHECK/SETTLE) a new start is not honoured.
  assign start_acc = cfg.cfg_start && (state_q inside {ST_IDLE, ST_RECV, ST_DONE, ST_ERR});

  aibnd_red_deser #(.FRAME_W(FRAME_W)) u_deser (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_acc),
    .bit_rdy   (ready_q),
    .bit_vld   (cfg.cfg_valid),
    .bit_dat   (cfg.cfg_data),
    .frame_vld (frame_vld),
    .frame     (frame)
  );

  assign repair_en = frame[FRAME_W-1];
  assign idx       = frame[FRAME_W-2:1];
  assign bad_word  = (^frame) || (repair_en && (32'(idx) >= NUM_IO));

  always_comb begin
    therm = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      therm[i] = repair_en && (i >= 32'(idx));
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_en_d = shift_en_q;
    settle_d   = settle_q;
    done_d     = done_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_acc) begin
          state_d = ST_RECV;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_RECV: begin
        if (!start_acc && frame_vld) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (bad_word) begin
          state_d    = ST_ERR;
          shift_en_d = '0;
          err_d      = 1'b1;
          done_d     = 1'b0;
        end else begin
          state_d    = ST_SETTLE;
          shift_en_d = therm;
          settle_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d  = state_d inside {ST_RECV, ST_CHECK, ST_SETTLE};
    ready_d = (state_d == ST_RECV);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_en_q <= '0;
      settle_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_en_q <= shift_en_d;
      settle_q   <= settle_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign shift_en      = shift_en_q;
  assign red_busy      = busy_q;
  assign red_done      = done_q;
  assign red_err       = err_q;

endmodule

// File: tb/tb_aibnd_red_shift_ctrl.sv
// Scoreboard bench for the redundancy shift controller: each sent word queues its expected outcome,
// which is popped and compared when red_done or red_err is raised.
module tb_aibnd_red_shift_ctrl;

  logic        clk;
  logic        rst;
  logic [23:0] shift_en;
  logic        red_busy;
  logic        red_done;
  logic        red_err;

  aibnd_red_shift_ctrl_if cfg_if ();

  aibnd_red_shift_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .cfg      (cfg_if),
    .shift_en (shift_en),
    .red_busy (red_busy),
    .red_done (red_done),
    .red_err  (red_err)
  );

  typedef struct {
    logic [23:0] se;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: thermometer built by shifting an all-ones word.
  function automatic exp_t model(input logic en, input logic [4:0] idx, input logic bad_par);
    exp_t        e;
    logic [23:0] ones;
    ones = '1;
    e.err = bad_par || (en && (idx >= 5'd24));
    e.se  = (e.err || !en) ? 24'h0 : (ones << idx);
    return e;
  endfunction

  task automatic send_word(input logic en, input logic [4:0] idx, input logic bad_par,
                           input int max_gap, input int restart_after, input bit push);
    logic [6:0] fr;
    fr = {en, idx, (^{en, idx}) ^ bad_par};
    if (push) sbq.push_back(model(en, idx, bad_par));
    @(posedge clk); #1 cfg_if.cfg_start = 1'b1;
    @(posedge clk); #1 cfg_if.cfg_start = 1'b0;
    if (restart_after > 0) begin
      for (int k = 0; k < restart_after; k++) begin
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data  = 1'($urandom);
        @(posedge clk); #1;
      end
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_start = 1'b1;
      @(posedge clk); #1 cfg_if.cfg_start = 1'b0;
    end
    for (int b = 6; b >= 0; b--) begin
      repeat ($urandom_range(max_gap, 0)) begin
        cfg_if.cfg_valid = 1'b0;
        @(posedge clk); #1;
      end
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_data  = fr[b];
      @(posedge clk); #1;
    end
    cfg_if.cfg_valid = 1'b0;
  endtask

  // Entered just after the edge that took the last bit; lat counts edges from that one.
  task automatic wait_result(input string tag);
    int   lat;
    exp_t e;
    lat = 1;
    while (!(red_done === 1'b1 || red_err === 1'b1) && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(sbq.size()), 64'd1);
    end else begin
      e = sbq.pop_front();
      if (!(red_done === 1'b1 || red_err === 1'b1)) begin
        chk({tag, "_timeout"}, 64'(lat), 64'd0);
      end else begin
        chk({tag, "_shift_en"}, 64'(shift_en), 64'(e.se));
        chk({tag, "_err"}, 64'(red_err), 64'(e.err));
        chk({tag, "_done"}, 64'(red_done), 64'(!e.err));
        chk({tag, "_busy"}, 64'(red_busy), 64'd0);
        chk({tag, "_lat"}, 64'(lat), e.err ? 64'd2 : 64'd10);
      end
    end
  endtask

  // shift_en must stay frozen across consecutive receive cycles.
  logic [23:0] se_prev;
  logic        rdy_prev;
  always @(negedge clk) begin
    if (!rst && rdy_prev && cfg_if.cfg_ready) chk("recv_hold", 64'(shift_en), 64'(se_prev));
    se_prev  <= shift_en;
    rdy_prev <= cfg_if.cfg_ready && !rst;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    cfg_if.cfg_start = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_shift_en", 64'(shift_en), 64'd0);
    chk("rst_ready", 64'(cfg_if.cfg_ready), 64'd0);
    chk("rst_busy", 64'(red_busy), 64'd0);
    chk("rst_done", 64'(red_done), 64'd0);
    chk("rst_err", 64'(red_err), 64'd0);
    rst = 1'b0;

    // valid bit without ready is dropped
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = 1'b1;
    @(posedge clk); #1;
    cfg_if.cfg_valid = 1'b0;
    chk("idle_busy", 64'(red_busy), 64'd0);

    send_word(1'b1, 5'd5, 1'b0, 0, 0, 1'b1);
    wait_result("s1_idx5");

    send_word(1'b0, 5'd0, 1'b0, 0, 0, 1'b1);
    wait_result("s2_noreq");
    send_word(1'b1, 5'd23, 1'b0, 0, 0, 1'b1);
    chk("s2_busy_mid", 64'(red_busy), 64'd1);
    wait_result("s2_idx23");

    send_word(1'b1, 5'd3, 1'b0, 0, 0, 1'b1);
    wait_result("s3_idx3");
    send_word(1'b1, 5'd3, 1'b1, 0, 0, 1'b1);
    wait_result("s3_badpar");

    send_word(1'b1, 5'd30, 1'b0, 0, 0, 1'b1);
    wait_result("s4_oob");
    send_word(1'b0, 5'd30, 1'b0, 0, 0, 1'b1);
    wait_result("s4_oob_off");

    send_word(1'b1, 5'd0, 1'b0, 2, 0, 1'b1);
    wait_result("s4_idx0");

    send_word(1'b1, 5'd5, 1'b0, 5, 0, 1'b1);
    wait_result("s5_gaps");
    send_word(1'b1, 5'd9, 1'b0, 0, 0, 1'b1);
    wait_result("s5_idx9");
    send_word(1'b1, 5'd5, 1'b0, 3, 3, 1'b1);
    wait_result("s5_restart");

    send_word(1'b1, 5'd2, 1'b0, 0, 0, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("s6_settle_busy", 64'(red_busy), 64'd1);
    chk("s6_settle_se", 64'(shift_en), 64'hFFFFFC);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("s6_rst_se", 64'(shift_en), 64'd0);
    chk("s6_rst_busy", 64'(red_busy), 64'd0);
    chk("s6_rst_done", 64'(red_done), 64'd0);

    send_word(1'b1, 5'd12, 1'b0, 1, 0, 1'b1);
    wait_result("s6_recover");

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
